// File: rtl/multdiv_controller_if.sv
// multdiv_controller_if
//   Start/operand/result bundle between execute-stage decode and the
//   multi-cycle multiply/divide sequencer.
//   master : decode/pipeline side -- drives starts, flush, operands;
//            receives result, exception, ready pulse, busy and stall.
//   slave  : sequencer side.
interface multdiv_controller_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        flush;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic        stall;

  modport master (
    output ctrl_MULT, ctrl_DIV, flush, operandA, operandB,
    input  data_result, data_exception, data_resultRDY, busy, stall
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, flush, operandA, operandB,
    output data_result, data_exception, data_resultRDY, busy, stall
  );
endinterface

// File: rtl/multdiv_controller.sv
// multdiv_controller
//   Execute-stage sequencer for 32-iteration signed multiply (shift-add,
//   LSB first) and restoring divide (MSB first) on operand magnitudes.
//   A start accepted in cycle 0 yields a one-cycle data_resultRDY pulse
//   in cycle 33 for every operand value; stall holds the front of the
//   pipeline until then.
//   Ports:
//     clock    rising-edge clock
//     reset_n  synchronous active-low reset
//     bus      multdiv_controller_if.slave: ctrl_MULT/ctrl_DIV start
//              pulses, flush, operandA/B in; data_result,
//              data_exception, data_resultRDY, busy, stall out
module multdiv_controller (
  input  logic                  clock,
  input  logic                  reset_n,
  multdiv_controller_if.slave   bus
);

  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  // MUL: op_a = shifted multiplicand, op_b = multiplier (shifted right),
  //      acc = partial product.
  // DIV: op_a[31:0] = dividend shifting out / quotient shifting in,
  //      op_b = divisor, acc[31:0] = partial remainder.
  logic [63:0] op_a;
  logic [31:0] op_b;
  logic [63:0] acc;
  logic        neg;
  logic        b_zero;
  logic        div_ovf;

  logic        in_op, accept, last;
  logic [31:0] a_mag, b_mag;
  logic [63:0] acc_mul;
  logic [31:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] rem_next, quo_next;
  logic [63:0] mag, signed_res;
  logic        mul_ovf;
  logic [31:0] final_res;
  logic        final_exc;

  assign in_op  = (state == MUL) || (state == DIV);
  assign accept = reset_n && !bus.flush && ((state == IDLE) || (state == DONE))
                  && (bus.ctrl_MULT || bus.ctrl_DIV);
  assign last   = in_op && (cnt == 5'(ITER - 1));

  assign a_mag = bus.operandA[31] ? -bus.operandA : bus.operandA;
  assign b_mag = bus.operandB[31] ? -bus.operandB : bus.operandB;

  // Remainder stays below the divisor (<= 2^31), so the shifted partial
  // remainder always fits in 32 bits; only the divide-by-zero case
  // overflows it, and that result is replaced anyway.
  always_comb begin
    acc_mul  = acc + (op_b[0] ? op_a : '0);
    shifted  = {acc[30:0], op_a[31]};
    diff     = {1'b0, shifted} - {1'b0, op_b};
    q_bit    = ~diff[32];
    rem_next = q_bit ? diff[31:0] : shifted;
    quo_next = {op_a[30:0], q_bit};

    mag        = (state == MUL) ? acc_mul : {32'b0, quo_next};
    signed_res = neg ? -mag : mag;
    // Signed product fits in 32 bits iff bits 63..31 are all equal.
    mul_ovf    = !((&signed_res[63:31]) || !(|signed_res[63:31]));

    final_res = signed_res[31:0];
    final_exc = 1'b0;
    if (state == MUL) begin
      final_exc = mul_ovf;
    end else if (b_zero) begin
      final_res = '0;
      final_exc = 1'b1;
    end else begin
      final_exc = div_ovf;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (bus.ctrl_MULT)     state_next = MUL;
        else if (bus.ctrl_DIV) state_next = DIV;
        else                   state_next = IDLE;
      end
      MUL, DIV: begin
        if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt                <= '0;
      op_a               <= '0;
      op_b               <= '0;
      acc                <= '0;
      neg                <= 1'b0;
      b_zero             <= 1'b0;
      div_ovf            <= 1'b0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      op_a    <= {32'b0, a_mag};
      op_b    <= b_mag;
      acc     <= '0;
      neg     <= bus.operandA[31] ^ bus.operandB[31];
      b_zero  <= (bus.operandB == '0);
      div_ovf <= (bus.operandA == 32'h8000_0000) && (bus.operandB == '1);
    end else if (in_op && !bus.flush) begin
      cnt <= cnt + 5'd1;
      if (state == MUL) begin
        acc  <= acc_mul;
        op_a <= op_a << 1;
        op_b <= op_b >> 1;
      end else begin
        acc  <= {32'b0, rem_next};
        op_a <= {32'b0, quo_next};
      end
      if (last) begin
        bus.data_result    <= final_res;
        bus.data_exception <= final_exc;
      end
    end
  end

  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = in_op;
  assign bus.stall          = in_op || accept;

endmodule

// File: tb/tb_multdiv_controller.sv
// tb_multdiv_controller
//   Directed bench for multdiv_controller: reset, signed multiply and
//   divide vectors with exception boundaries, simultaneous starts,
//   back-to-back ops, flush and reset mid-op.
module tb_multdiv_controller;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   fails  = 0;

  multdiv_controller_if bus ();

  multdiv_controller dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Drives a start in cycle 0 and observes cycles 1..33.
  task automatic run_op(input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic stall0, output int rdy_cycle,
                        output int rdy_count, output int prof_errs,
                        output logic [31:0] res, output logic exc);
    @(negedge clock);
    bus.ctrl_MULT = m;
    bus.ctrl_DIV  = d;
    bus.operandA  = a;
    bus.operandB  = b;
    #1 stall0 = bus.stall;
    rdy_cycle = 0;
    rdy_count = 0;
    prof_errs = 0;
    res       = '0;
    exc       = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clock);
      if (n == 1) begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
      end
      #1;
      if (bus.data_resultRDY === 1'b1) begin
        rdy_count++;
        if (rdy_cycle == 0) rdy_cycle = n;
        res = bus.data_result;
        exc = bus.data_exception;
      end
      if (bus.busy !== 1'(n <= 32) || bus.stall !== 1'(n <= 32)) prof_errs++;
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV  = 1'b0;
    bus.flush     = 1'b1;
    bus.operandA  = 32'd3;
    bus.operandB  = 32'd4;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (bus.data_result !== 32'h0 || bus.data_exception !== 1'b0 ||
        bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: res=%h exc=%b rdy=%b busy=%b stall=%b, required all 0",
               bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy, bus.stall);
    end
    @(negedge clock);
    reset_n       = 1'b1;
    bus.ctrl_MULT = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic test_vectors(input logic is_mul);
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] vr [7];
    logic        ve [7];
    logic        s0;
    int          rc, rn, pe;
    logic [31:0] r;
    logic        e;
    if (is_mul) begin
      va = '{32'd7,        32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_0000, 32'h0000_8000, 32'd0};
      vb = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1,        32'hFFFF_FFFF, 32'h0000_8000, 32'h0001_0000, 32'hFFFF_FFFF};
      vr = '{32'hFFFF_FFD6, 32'h0,        32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0};
      ve = '{1'b0,          1'b1,          1'b0,          1'b1,          1'b0,          1'b1,          1'b0};
    end else begin
      va = '{32'hFFFF_FFF9, 32'd7,  32'h8000_0000, 32'd100,       32'h8000_0000, 32'd5, 32'h8000_0000};
      vb = '{32'd2,         32'd0,  32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd2,         32'd7, 32'h8000_0000};
      vr = '{32'hFFFF_FFFD, 32'h0,  32'h8000_0000, 32'hFFFF_FFF2, 32'hC000_0000, 32'h0, 32'h1};
      ve = '{1'b0,          1'b1,   1'b1,          1'b0,          1'b0,          1'b0,  1'b0};
    end
    for (int i = 0; i < 7; i++) begin
      run_op(is_mul, !is_mul, va[i], vb[i], s0, rc, rn, pe, r, e);
      checks++;
      if (s0 !== 1'b1) begin
        fails++;
        $display("FAIL %s[%0d] stall_cycle0: got %b, required 1", is_mul ? "mul" : "div", i, s0);
      end
      checks++;
      if (rc != 33 || rn != 1) begin
        fails++;
        $display("FAIL %s[%0d] rdy_timing: first rdy cycle %0d pulses %0d, required cycle 33 pulses 1",
                 is_mul ? "mul" : "div", i, rc, rn);
      end
      checks++;
      if (pe != 0) begin
        fails++;
        $display("FAIL %s[%0d] busy_stall_profile: %0d bad cycles, required 0", is_mul ? "mul" : "div", i, pe);
      end
      checks++;
      if (r !== vr[i] || e !== ve[i]) begin
        fails++;
        $display("FAIL %s[%0d] result: got %h exc %b, required %h exc %b",
                 is_mul ? "mul" : "div", i, r, e, vr[i], ve[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic        s0;
    int          rc, rn, pe;
    logic [31:0] r;
    logic        e;
    run_op(1'b1, 1'b1, 32'd9, 32'd3, s0, rc, rn, pe, r, e);
    checks++;
    if (rc != 33 || r !== 32'd27 || e !== 1'b0) begin
      fails++;
      $display("FAIL simultaneous_start: rdy cycle %0d res %h exc %b, required cycle 33 res 0000001b exc 0", rc, r, e);
    end
  endtask

  task automatic test_back_to_back();
    int rdy_count = 0;
    int rdy_bad   = 0;
    @(negedge clock);
    bus.ctrl_MULT = 1'b1;
    bus.operandA  = 32'd5;
    bus.operandB  = 32'd6;
    for (int n = 1; n <= 66; n++) begin
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
      if (n == 10) begin
        bus.ctrl_MULT = 1'b1;
        bus.operandA  = 32'd100;
        bus.operandB  = 32'd100;
      end
      if (n == 33) begin
        bus.ctrl_DIV = 1'b1;
        bus.operandA = 32'd50;
        bus.operandB = 32'hFFFF_FFFB;
      end
      #1;
      if (bus.data_resultRDY === 1'b1) begin
        rdy_count++;
        if (n != 33 && n != 66) rdy_bad++;
      end
      if (n == 33) begin
        checks++;
        if (bus.data_resultRDY !== 1'b1 || bus.data_result !== 32'd30 || bus.stall !== 1'b1) begin
          fails++;
          $display("FAIL b2b_first: rdy %b res %h stall %b, required rdy 1 res 0000001e stall 1",
                   bus.data_resultRDY, bus.data_result, bus.stall);
        end
      end
      if (n == 34) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_second_busy: got %b, required 1", bus.busy);
        end
      end
      if (n == 66) begin
        checks++;
        if (bus.data_resultRDY !== 1'b1 || bus.data_result !== 32'hFFFF_FFF6 || bus.data_exception !== 1'b0) begin
          fails++;
          $display("FAIL b2b_second: rdy %b res %h exc %b, required rdy 1 res fffffff6 exc 0",
                   bus.data_resultRDY, bus.data_result, bus.data_exception);
        end
      end
    end
    checks++;
    if (rdy_count != 2 || rdy_bad != 0) begin
      fails++;
      $display("FAIL b2b_pulses: %0d pulses, %0d misplaced, required 2 and 0", rdy_count, rdy_bad);
    end
  endtask

  task automatic test_flush();
    int rdy_count = 0;
    @(negedge clock);
    bus.ctrl_MULT = 1'b1;
    bus.operandA  = 32'd3;
    bus.operandB  = 32'd4;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      if (n == 15) bus.flush = 1'b1;
      #1;
      if (bus.data_resultRDY === 1'b1) rdy_count++;
      if (n == 16) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          fails++;
          $display("FAIL flush_busy: got %b, required 0", bus.busy);
        end
        bus.flush = 1'b0;
      end
    end
    checks++;
    if (rdy_count != 0 || bus.data_result !== 32'hFFFF_FFF6 || bus.data_exception !== 1'b0) begin
      fails++;
      $display("FAIL flush_hold: pulses %0d res %h exc %b, required 0 fffffff6 0",
               rdy_count, bus.data_result, bus.data_exception);
    end
    @(negedge clock);
    bus.flush     = 1'b1;
    bus.ctrl_MULT = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_with_start_stall: got %b, required 0", bus.stall);
    end
    @(negedge clock);
    bus.flush     = 1'b0;
    bus.ctrl_MULT = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_with_start_busy: got %b, required 0", bus.busy);
    end
  endtask

  task automatic test_reset_midop();
    int          rdy_count = 0;
    logic        s0;
    int          rc, rn, pe;
    logic [31:0] r;
    logic        e;
    @(negedge clock);
    bus.ctrl_DIV = 1'b1;
    bus.operandA = 32'd100;
    bus.operandB = 32'd7;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      bus.ctrl_DIV = 1'b0;
      if (n == 20) reset_n = 1'b0;
      #1;
      if (bus.data_resultRDY === 1'b1) rdy_count++;
      if (n == 21) begin
        checks++;
        if (bus.data_result !== 32'h0 || bus.data_exception !== 1'b0 ||
            bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
          fails++;
          $display("FAIL reset_midop: res=%h exc=%b rdy=%b busy=%b stall=%b, required all 0",
                   bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy, bus.stall);
        end
        reset_n = 1'b1;
      end
    end
    checks++;
    if (rdy_count != 0) begin
      fails++;
      $display("FAIL reset_midop_rdy: %0d pulses, required 0", rdy_count);
    end
    run_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3, s0, rc, rn, pe, r, e);
    checks++;
    if (rc != 33 || r !== 32'hFFFF_FFFA || e !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_op: rdy cycle %0d res %h exc %b, required 33 fffffffa 0", rc, r, e);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.flush     = 1'b0;
    bus.operandA  = '0;
    bus.operandB  = '0;
    test_reset();
    test_vectors(1'b1);
    test_vectors(1'b0);
    test_simultaneous();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
